// File: rtl/decode_stage.sv
// decode_stage: queued RV32I(M) decode stage between fetch and register-read.
//
// Fetched {instr, pc} pairs go into a small circular FIFO. The head entry is
// decoded combinationally and loaded into an output register that sits
// behind a valid/ready handshake.
//
// Handshake rules: a beat moves on any rising edge where valid and ready are
// both high. The producer holds its data stable while valid is high and
// ready is low. in_ready depends only on registered state and never on
// out_ready.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   flush              drop every queued entry and the output register
//   in_valid/in_ready  fetch-side handshake; in_instr, in_pc are the payload
//   out_valid/out_ready consumer-side handshake; out_pc plus the decoded
//                      fields (alu_ops, memory controls, format flags,
//                      register indices and uses, imm, illegal)
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int QUEUE_DEPTH = 2,
    parameter int M_EXT       = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      alu_ops,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_unsigned,
    output logic [1:0]      mem_width,
    output logic            is_lui,
    output logic            is_auipc,
    output logic            is_i_type,
    output logic            is_branch,
    output logic            is_jal,
    output logic            is_jalr,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            rs1_used,
    output logic            rs2_used,
    output logic [31:0]     imm,
    output logic            illegal
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [3:0]  alu_ops;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_unsigned;
        logic [1:0]  mem_width;
        logic        is_lui;
        logic        is_auipc;
        logic        is_i_type;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_used;
        logic        rs2_used;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    logic [31:0]      q_instr [QUEUE_DEPTH];
    logic [XLEN-1:0]  q_pc    [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, load;
    dec_t             d, q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = (count < CNT_W'(QUEUE_DEPTH));
    assign push     = in_valid && in_ready;
    // The output register takes a new entry whenever it is empty or being consumed.
    assign load     = (!out_valid || out_ready) && (count != '0);

    // ---------------- head decode ----------------
    logic [31:0] h;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        legal;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign h      = q_instr[rd_ptr];
    assign opcode = h[6:0];
    assign f3     = h[14:12];
    assign f7     = h[31:25];
    assign imm_i  = {{20{h[31]}}, h[31:20]};
    assign imm_s  = {{20{h[31]}}, h[31:25], h[11:7]};
    assign imm_b  = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
    assign imm_u  = {h[31:12], 12'h000};
    assign imm_j  = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};

    always_comb begin
        d        = '0;
        legal    = 1'b1;
        case (opcode)
            7'b0110111: begin d.is_lui = 1'b1; d.reg_write = 1'b1; d.imm = imm_u; end
            7'b0010111: begin d.is_auipc = 1'b1; d.reg_write = 1'b1; d.imm = imm_u; end
            7'b1101111: begin d.is_jal = 1'b1; d.reg_write = 1'b1; d.imm = imm_j; end
            7'b1100111: begin
                d.is_jalr = 1'b1; d.is_i_type = 1'b1; d.reg_write = 1'b1;
                d.rs1_used = 1'b1; d.imm = imm_i;
                legal = (f3 == 3'b000);
            end
            7'b1100011: begin
                d.is_branch = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1; d.imm = imm_b;
                case (f3)
                    3'b000:  d.alu_ops = 4'b0000;
                    3'b001:  d.alu_ops = 4'b0001;
                    3'b100:  d.alu_ops = 4'b0010;
                    3'b101:  d.alu_ops = 4'b0011;
                    3'b110:  d.alu_ops = 4'b0100;
                    3'b111:  d.alu_ops = 4'b0101;
                    default: legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                d.mem_read = 1'b1; d.reg_write = 1'b1; d.is_i_type = 1'b1;
                d.rs1_used = 1'b1; d.imm = imm_i;
                d.mem_width = f3[1:0]; d.mem_unsigned = f3[2];
                legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            7'b0100011: begin
                d.mem_write = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1;
                d.imm = imm_s; d.mem_width = f3[1:0];
                legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
            end
            7'b0010011: begin
                d.is_i_type = 1'b1; d.reg_write = 1'b1; d.rs1_used = 1'b1; d.imm = imm_i;
                case (f3)
                    3'b000: d.alu_ops = 4'b0000;
                    3'b010: d.alu_ops = 4'b1001;
                    3'b011: d.alu_ops = 4'b1011;
                    3'b100: d.alu_ops = 4'b0010;
                    3'b110: d.alu_ops = 4'b0011;
                    3'b111: d.alu_ops = 4'b0100;
                    3'b001: begin d.alu_ops = 4'b0101; legal = (f7 == 7'b0000000); end
                    default: begin
                        // The shift-right immediates carry the arithmetic/logical choice in funct7.
                        if (f7 == 7'b0000000)      d.alu_ops = 4'b0110;
                        else if (f7 == 7'b0100000) d.alu_ops = 4'b1000;
                        else                       legal = 1'b0;
                    end
                endcase
            end
            7'b0110011: begin
                d.reg_write = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  d.alu_ops = 4'b0000;
                            3'b001:  d.alu_ops = 4'b0101;
                            3'b010:  d.alu_ops = 4'b1001;
                            3'b011:  d.alu_ops = 4'b1011;
                            3'b100:  d.alu_ops = 4'b0010;
                            3'b101:  d.alu_ops = 4'b0110;
                            3'b110:  d.alu_ops = 4'b0011;
                            default: d.alu_ops = 4'b0100;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000)      d.alu_ops = 4'b0001;
                        else if (f3 == 3'b101) d.alu_ops = 4'b1000;
                        else                   legal = 1'b0;
                    end
                    7'b0000001: begin
                        if (M_EXT == 0) legal = 1'b0;
                        else begin
                            case (f3)
                                3'b000:  d.alu_ops = 4'b1100;
                                3'b100:  d.alu_ops = 4'b1101;
                                3'b101:  d.alu_ops = 4'b0111;
                                3'b110:  d.alu_ops = 4'b1110;
                                3'b111:  d.alu_ops = 4'b1010;
                                default: legal = 1'b0;   // MULH family unsupported
                            endcase
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            7'b0001111: ;   // FENCE: legal, no side effects
            default: legal = 1'b0;
        endcase

        // An illegal word carries only its raw register fields and the flag.
        if (!legal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        d.rs1 = h[19:15];
        d.rs2 = h[24:20];
        d.rd  = h[11:7];
        if (d.rd == 5'd0) d.reg_write = 1'b0;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            q_instr[wr_ptr] <= in_instr;
            q_pc[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            q         <= '0;
        end else if (flush) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (load) rd_ptr <= next_ptr(rd_ptr);
            if (push && !load)      count <= count + 1'b1;
            else if (!push && load) count <= count - 1'b1;
            if (load) begin
                q         <= d;
                out_pc    <= q_pc[rd_ptr];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign alu_ops      = q.alu_ops;
    assign reg_write    = q.reg_write;
    assign mem_read     = q.mem_read;
    assign mem_write    = q.mem_write;
    assign mem_unsigned = q.mem_unsigned;
    assign mem_width    = q.mem_width;
    assign is_lui       = q.is_lui;
    assign is_auipc     = q.is_auipc;
    assign is_i_type    = q.is_i_type;
    assign is_branch    = q.is_branch;
    assign is_jal       = q.is_jal;
    assign is_jalr      = q.is_jalr;
    assign rs1          = q.rs1;
    assign rs2          = q.rs2;
    assign rd           = q.rd;
    assign rs1_used     = q.rs1_used;
    assign rs2_used     = q.rs2_used;
    assign imm          = q.imm;
    assign illegal      = q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: two instances (M extension on and off) share
// one stimulus stream. Accepted instructions go into an expected queue and a
// monitor compares every consumed bundle against a table-driven reference
// decoder.
module tb_decode_stage;
    localparam int D = 2;

    typedef struct packed {
        logic [3:0]  alu;
        logic        rw, mr, mw, mu;
        logic [1:0]  mwid;
        logic        lui, auipc, itype, br, jal, jalr;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        ir_a, ov_a, ir_b, ov_b;
    logic [31:0] pc_a, pc_b;
    wire  [65:0] bus_a, bus_b;
    dec_t        got_a, got_b;
    assign got_a = bus_a;
    assign got_b = bus_b;

    logic [63:0] exp_q[$];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .QUEUE_DEPTH(D), .M_EXT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov_a), .out_ready(out_ready),
        .out_pc(pc_a), .alu_ops(bus_a[65:62]), .reg_write(bus_a[61]), .mem_read(bus_a[60]),
        .mem_write(bus_a[59]), .mem_unsigned(bus_a[58]), .mem_width(bus_a[57:56]),
        .is_lui(bus_a[55]), .is_auipc(bus_a[54]), .is_i_type(bus_a[53]), .is_branch(bus_a[52]),
        .is_jal(bus_a[51]), .is_jalr(bus_a[50]), .rs1(bus_a[49:45]), .rs2(bus_a[44:40]),
        .rd(bus_a[39:35]), .rs1_used(bus_a[34]), .rs2_used(bus_a[33]), .imm(bus_a[32:1]),
        .illegal(bus_a[0]));

    decode_stage #(.XLEN(32), .QUEUE_DEPTH(D), .M_EXT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov_b), .out_ready(out_ready),
        .out_pc(pc_b), .alu_ops(bus_b[65:62]), .reg_write(bus_b[61]), .mem_read(bus_b[60]),
        .mem_write(bus_b[59]), .mem_unsigned(bus_b[58]), .mem_width(bus_b[57:56]),
        .is_lui(bus_b[55]), .is_auipc(bus_b[54]), .is_i_type(bus_b[53]), .is_branch(bus_b[52]),
        .is_jal(bus_b[51]), .is_jalr(bus_b[50]), .rs1(bus_b[49:45]), .rs2(bus_b[44:40]),
        .rd(bus_b[39:35]), .rs1_used(bus_b[34]), .rs2_used(bus_b[33]), .imm(bus_b[32:1]),
        .illegal(bus_b[0]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Reference decoder: opcode classes with lookup tables per funct3.
    function automatic dec_t model(input logic [31:0] i, input bit m_ext);
        dec_t e;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic signed [31:0] s;
        logic [31:0] ii, si, bi, ui, ji;
        logic [3:0] base_op [8];
        logic [3:0] m_op [8];
        logic [3:0] br_op [8];
        logic [7:0] m_ok, br_ok, ld_ok, st_ok;
        bit ok;
        base_op = '{4'd0, 4'd5, 4'd9, 4'd11, 4'd2, 4'd6, 4'd3, 4'd4};
        m_op    = '{4'd12, 4'd0, 4'd0, 4'd0, 4'd13, 4'd7, 4'd14, 4'd10};
        br_op   = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5};
        m_ok  = 8'b1111_0001;
        br_ok = 8'b1111_0011;
        ld_ok = 8'b0011_0111;
        st_ok = 8'b0000_0111;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        s  = i;
        ii = 32'(s >>> 20);
        si = {ii[31:5], i[11:7]};
        bi = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        ui = {i[31:12], 12'h000};
        ji = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        e = '0;
        ok = 1;
        case (op)
            7'h37: begin e.lui = 1; e.rw = 1; e.imm = ui; end
            7'h17: begin e.auipc = 1; e.rw = 1; e.imm = ui; end
            7'h6F: begin e.jal = 1; e.rw = 1; e.imm = ji; end
            7'h67: begin e.jalr = 1; e.itype = 1; e.rw = 1; e.u1 = 1; e.imm = ii; ok = (f3 == 0); end
            7'h63: begin e.br = 1; e.u1 = 1; e.u2 = 1; e.imm = bi; e.alu = br_op[f3]; ok = br_ok[f3]; end
            7'h03: begin
                e.mr = 1; e.rw = 1; e.itype = 1; e.u1 = 1; e.imm = ii;
                e.mwid = f3[1:0]; e.mu = f3[2]; ok = ld_ok[f3];
            end
            7'h23: begin e.mw = 1; e.u1 = 1; e.u2 = 1; e.imm = si; e.mwid = f3[1:0]; ok = st_ok[f3]; end
            7'h13: begin
                e.itype = 1; e.rw = 1; e.u1 = 1; e.imm = ii; e.alu = base_op[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    if (f7 == 7'h20) e.alu = 4'd8;
                    else ok = (f7 == 0);
                end
            end
            7'h33: begin
                e.rw = 1; e.u1 = 1; e.u2 = 1;
                if (f7 == 0) e.alu = base_op[f3];
                else if (f7 == 7'h20) begin
                    ok = (f3 == 0) || (f3 == 5);
                    e.alu = (f3 == 0) ? 4'd1 : 4'd8;
                end else if (f7 == 7'h01) begin
                    ok = m_ext && m_ok[f3];
                    e.alu = m_op[f3];
                end else ok = 0;
            end
            7'h0F: ;
            default: ok = 0;
        endcase
        if (!ok) begin e = '0; e.ill = 1; end
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        int k, r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = ops[k];
        r = $urandom_range(0, 3);
        if (r == 0) w[31:25] = 7'h00;
        else if (r == 1) w[31:25] = 7'h20;
        else if (r == 2) w[31:25] = 7'h01;
        return w;
    endfunction

    // Expected-queue capture: a beat is accepted at the edge following this sample.
    always @(negedge clk) begin
        if (!rst_n || flush) exp_q.delete();
        else if (in_valid && ir_a) exp_q.push_back({in_pc, in_instr});
    end

    // Monitor: compare each bundle that the consumer is about to take.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && !flush && ov_a && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_out: out_valid=1 pc=%h with nothing pending", pc_a);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_a", 128'(pc_a), 128'(e[63:32]));
                    chk("dec_a", 128'(got_a), 128'(model(e[31:0], 1'b1)));
                    chk("pc_b", 128'({ov_b, pc_b}), 128'({1'b1, e[63:32]}));
                    chk("dec_b", 128'(got_b), 128'(model(e[31:0], 1'b0)));
                end
            end
        end
    end

    // Drive one beat, starting just after a rising edge; returns just after the accepting edge.
    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        logic acc;
        bit done;
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk); acc = ir_a;
            @(posedge clk); #1;
            done = acc;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL push_timeout: pc=%h not accepted within 100 cycles", pc);
        end
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic fill_queue(input logic [31:0] pc0);
        out_ready = 1'b0;
        for (int k = 0; k < D + 1; k++) push_one(rand_instr(), pc0 + 32'(4 * k));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] first_i, first_pc;
        // ---------- reset ----------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(ov_a), 128'(0));
        chk("rst_out_pc", 128'(pc_a), 128'(0));
        chk("rst_bundle", 128'(got_a), 128'(0));
        chk("rst_in_ready", 128'(ir_a), 128'(1));
        rst_n = 1'b1;
        step();

        // ---------- ADDI then SW back to back ----------
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100;
        step();
        chk("lat_not_yet", 128'(ov_a), 128'(0));
        in_instr = 32'h0020A423; in_pc = 32'h104;
        step();
        in_valid = 1'b0;
        chk("addi_valid", 128'({ov_a, pc_a}), 128'({1'b1, 32'h100}));
        chk("addi_fields", 128'({got_a.alu, got_a.imm, got_a.rw}), 128'({4'b0000, 32'hFFFFFFFF, 1'b1}));
        step();
        chk("sw_valid", 128'({ov_a, pc_a}), 128'({1'b1, 32'h104}));
        chk("sw_fields", 128'({got_a.mw, got_a.mwid, got_a.imm, got_a.rw}), 128'({1'b1, 2'b10, 32'd8, 1'b0}));
        step();

        // ---------- immediates and M decode ----------
        push_one(32'hFE000EE3, 32'h200); step();
        chk("beq_imm", 128'({ov_a, got_a.br, got_a.imm}), 128'({1'b1, 1'b1, 32'hFFFFFFFC}));
        push_one(32'h001000EF, 32'h204); step();
        chk("jal_imm", 128'({ov_a, got_a.jal, got_a.imm}), 128'({1'b1, 1'b1, 32'h00000800}));
        push_one(32'h123450B7, 32'h208); step();
        chk("lui_imm", 128'({ov_a, got_a.lui, got_a.imm}), 128'({1'b1, 1'b1, 32'h12345000}));
        push_one(32'h025241B3, 32'h20C); step();
        chk("div_m1", 128'({got_a.alu, got_a.ill}), 128'({4'b1101, 1'b0}));
        chk("div_m0", 128'({ov_b, got_b.ill, got_b.rw}), 128'({1'b1, 1'b1, 1'b0}));
        push_one(32'h00000000, 32'h210); step();
        chk("zero_illegal", 128'({ov_a, got_a.ill, got_a.rw}), 128'({1'b1, 1'b1, 1'b0}));
        step();

        // ---------- backpressure ----------
        first_i = 32'h00A00513; first_pc = 32'h300;   // ADDI x10,x0,10
        out_ready = 1'b0;
        push_one(first_i, first_pc);
        for (int k = 1; k < D + 1; k++) push_one(rand_instr(), first_pc + 32'(4 * k));
        chk("bp_in_ready_low", 128'(ir_a), 128'(0));
        in_valid = 1'b1; in_instr = rand_instr(); in_pc = first_pc + 32'(4 * (D + 1));
        repeat (3) step();
        chk("bp_frozen_pc", 128'({ov_a, pc_a}), 128'({1'b1, first_pc}));
        chk("bp_frozen_dec", 128'(got_a), 128'(model(first_i, 1'b1)));
        chk("bp_still_full", 128'(ir_a), 128'(0));
        out_ready = 1'b1;
        begin
            bit done = 0;
            logic acc;
            for (int c = 0; c < 50 && !done; c++) begin
                @(negedge clk); acc = ir_a;
                @(posedge clk); #1;
                done = acc;
            end
            chk("bp_last_accepted", 128'(done), 128'(1));
        end
        in_valid = 1'b0;
        repeat (8) step();
        chk("bp_drained", 128'(exp_q.size()), 128'(0));

        // ---------- flush with full queue ----------
        fill_queue(32'h400);
        in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h4F0;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 128'(ov_a), 128'(0));
        chk("flush_in_ready", 128'(ir_a), 128'(1));
        out_ready = 1'b1;
        repeat (4) step();
        chk("flush_nothing_left", 128'(ov_a), 128'(0));
        // flush overrides a push that would otherwise be accepted
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h500;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) step();
        chk("flush_drops_push", 128'(ov_a), 128'(0));

        // ---------- reset mid-stream ----------
        fill_queue(32'h600);
        in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h6F0;
        rst_n = 1'b0;
        step();
        chk("rst_mid_out", 128'({ov_a, pc_a}), 128'(0));
        chk("rst_mid_bundle", 128'(got_a), 128'(0));
        chk("rst_mid_in_ready", 128'(ir_a), 128'(1));
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        chk("rst_mid_nothing_left", 128'(ov_a), 128'(0));

        // ---------- random traffic ----------
        begin
            int sent = 0, cyc = 0;
            logic acc = 1'b0;
            in_pc = 32'h1000;
            while (sent < 400 && cyc < 20000) begin
                if (acc) sent++;
                if (!in_valid || acc) begin
                    if ($urandom_range(0, 3) != 0) begin
                        in_valid = 1'b1; in_instr = rand_instr(); in_pc = in_pc + 32'd4;
                    end else in_valid = 1'b0;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk); acc = in_valid && ir_a;
                step();
                cyc++;
            end
            in_valid = 1'b0;
            chk("rand_completed", 128'(sent), 128'(400));
        end
        out_ready = 1'b1;
        repeat (10) step();
        chk("rand_drained", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
